// File: rtl/pulse_window_arbiter.sv
// Round-robin arbiter granting one requester at a time a fixed-length high window on a shared
// pulse output, followed by a programmable number of mandatory low cycles.
module pulse_window_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [LEN_W-1:0] len,
  output logic             y,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gcnt, gcnt_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             done_nxt;

  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [LEN_W-1:0] eff_len;
  logic             arb;
  int               j;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  assign eff_len = (len == '0) ? LEN_W'(1) : len;

  // Arbitration happens in IDLE and also on the final cycle of GAP (or of PULSE when
  // there is no gap), so a held request is granted without an extra idle cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    done_nxt  = 1'b0;
    arb       = 1'b0;

    case (state)
      S_IDLE: arb = 1'b1;
      S_PULSE: begin
        if (cnt == LEN_W'(1)) begin
          done_nxt = 1'b1;
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gcnt_nxt  = 4'(GAP);
            gnt_nxt   = '0;
          end else begin
            arb = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - LEN_W'(1);
        end
      end
      S_GAP: begin
        if (gcnt == 4'd1) arb = 1'b1;
        else              gcnt_nxt = gcnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (arb) begin
      if (win_vld) begin
        state_nxt = S_PULSE;
        gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        cnt_nxt   = eff_len;
        ptr_nxt   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      end else begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      ptr   <= '0;
      gnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gcnt  <= gcnt_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
    end
  end

  assign y    = (state == S_PULSE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pulse_window_arbiter.sv
// Directed bench for pulse_window_arbiter: a GAP=1 instance driven from a vector table plus
// hand sequences, and a GAP=0 instance for back-to-back windows.
module tb_pulse_window_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, y, busy, done;
  logic [3:0] req, len, gnt;
  logic       z_rst, z_y, z_busy, z_done;
  logic [3:0] z_req, z_len, z_gnt;

  pulse_window_arbiter #(.NREQ(4), .LEN_W(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len),
    .y(y), .gnt(gnt), .busy(busy), .done(done)
  );

  pulse_window_arbiter #(.NREQ(4), .LEN_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst(z_rst), .req(z_req), .len(z_len),
    .y(z_y), .gnt(z_gnt), .busy(z_busy), .done(z_done)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] len;
    logic [6:0] exp;   // {y, gnt, busy, done} in the cycle after the edge
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ln,
                     input logic ey, input logic [3:0] eg, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln; v.exp = {ey, eg, eb, ed};
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got y=%b gnt=%b busy=%b done=%b, want y=%b gnt=%b busy=%b done=%b",
               name, act[6], act[5:2], act[1], act[0], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; len = '0;
    z_rst = 1'b1; z_req = '0; z_len = '0;

    // reset, reset beats request
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
    // single request len=3
    add(0, 4'b0001, 3, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 0, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 0, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // len=0 acts as 1
    add(0, 4'b0100, 0, 1, 4'b0100, 1, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // contention, pointer restarts at 0 after reset
    add(1, 4'b1111, 2, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b1111, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b1111, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 1, 4'b0010, 1, 0);
    add(0, 4'b1111, 2, 1, 4'b0010, 1, 0);
    add(0, 4'b1111, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 1, 4'b0100, 1, 0);
    add(0, 4'b1111, 2, 1, 4'b0100, 1, 0);
    add(0, 4'b1111, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 1, 4'b1000, 1, 0);
    add(0, 4'b1111, 2, 1, 4'b1000, 1, 0);
    add(0, 4'b1111, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 2, 0, 4'b0000, 0, 0);
    // owner drops req and len changes mid-window
    add(0, 4'b0010, 4, 1, 4'b0010, 1, 0);
    add(0, 4'b0000, 9, 1, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 1, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 1, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0);
    // pointer at 2 wraps to 0; req 0100 raised and dropped mid-window is ignored
    add(0, 4'b0001, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b0101, 2, 1, 4'b0001, 1, 0);
    add(0, 4'b0000, 2, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 2, 0, 4'b0000, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; len = tv[i].len;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {y, gnt, busy, done}, tv[i].exp);
    end

    // len = all-ones: 15 high cycles, no wrap
    @(negedge clk); req = 4'b1000; len = 4'd15;
    @(posedge clk); #1;
    chk("len15_c1", {y, gnt, busy, done}, {1'b1, 4'b1000, 1'b1, 1'b0});
    @(negedge clk); req = '0; len = '0;
    for (int k = 2; k <= 15; k++) begin
      @(posedge clk); #1;
      chk($sformatf("len15_c%0d", k), {y, gnt, busy, done}, {1'b1, 4'b1000, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    chk("len15_done", {y, gnt, busy, done}, {1'b0, 4'b0000, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("len15_idle", {y, gnt, busy, done}, {1'b0, 4'b0000, 1'b0, 1'b0});

    // reset during PULSE cycle 2 of len=5; next grant restarts from index 0
    @(negedge clk); req = 4'b0100; len = 4'd5;
    @(posedge clk); #1;
    chk("rst_c1", {y, gnt, busy, done}, {1'b1, 4'b0100, 1'b1, 1'b0});
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk("rst_c2", {y, gnt, busy, done}, {1'b1, 4'b0100, 1'b1, 1'b0});
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_abort", {y, gnt, busy, done}, {1'b0, 4'b0000, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0; req = 4'b1111; len = 4'd1;
    @(posedge clk); #1;
    chk("rst_regrant", {y, gnt, busy, done}, {1'b1, 4'b0001, 1'b1, 1'b0});
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk("rst_regrant_done", {y, gnt, busy, done}, {1'b0, 4'b0000, 1'b1, 1'b1});

    // GAP=0 instance: back-to-back alternating grants
    @(negedge clk); z_rst = 1'b0; z_req = 4'b0011; z_len = 4'd1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("gap0_c%0d", k), {z_y, z_gnt, z_busy, z_done},
          {1'b1, (k % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1, (k > 0) ? 1'b1 : 1'b0});
    end
    @(negedge clk); z_req = '0;
    @(posedge clk); #1;
    chk("gap0_end", {z_y, z_gnt, z_busy, z_done}, {1'b0, 4'b0000, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("gap0_idle", {z_y, z_gnt, z_busy, z_done}, {1'b0, 4'b0000, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
